mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data load/store port. One transaction is in flight at a time;
// data has priority, but fetch is guaranteed a grant after STARVE_MAX
// consecutive data grants made while fetch was waiting.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_BITS  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    // fetch port
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    input  logic                 if_flush,
    output logic                 if_done,
    output logic [XLEN-1:0]      if_rdata,
    output logic                 if_stall,
    // data port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    output logic                 d_done,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 d_stall,
    // memory port
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       flush_flag;
    logic       fetch_elig;
    logic       data_elig;
    logic       grant_i;
    logic       grant_d;

    // Requesters see a stall until the cycle their completion pulse is out.
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    // Arbitration and next-state: a port whose done pulse is showing this
    // cycle is not re-granted for the request it just completed.
    always_comb begin
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        fetch_elig = if_req & ~if_done & ~if_flush;
        data_elig  = d_req & ~d_done;
        case (state)
            IDLE: begin
                if (fetch_elig && data_elig) begin
                    if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
                    else                          grant_d = 1'b1;
                end else if (fetch_elig) begin
                    grant_i = 1'b1;
                end else if (data_elig) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_nxt = BUSY_I;
                else if (grant_d) state_nxt = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Starvation counter and sticky fetch-flush flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            flush_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_flag <= 1'b0;
                    if (grant_i) begin
                        starve_cnt <= 4'd0;
                    end else if (grant_d) begin
                        if (!if_req)                      starve_cnt <= 4'd0;
                        else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
                    end else if (!if_req) begin
                        starve_cnt <= 4'd0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready)     flush_flag <= 1'b0;
                    else if (if_flush) flush_flag <= 1'b1;
                end
                default: flush_flag <= 1'b0;
            endcase
        end
    end

    // Memory request registers, completion pulses and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end else if (grant_d) begin
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        // A flushed fetch still finishes on the memory but is
                        // invisible to the fetch port.
                        if (!(flush_flag || if_flush)) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        d_done <= 1'b1;
                        if (!mem_we) d_rdata <= mem_rdata;
                    end
                end
                default: mem_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int AB   = 8;
    localparam int SM   = 4;

    localparam int OWN_NONE  = 0;
    localparam int OWN_FETCH = 1;
    localparam int OWN_DATA  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, if_flush, d_req, d_we, mem_ready;
    logic [AB-1:0]   if_addr, d_addr;
    logic [XLEN-1:0] d_wdata, mem_rdata;
    logic            if_done, if_stall, d_done, d_stall, mem_en, mem_we;
    logic [XLEN-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AB-1:0]   mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_BITS(AB), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Reference model: who owns the memory, the request they hold, the
    // number of data wins while fetch was kept waiting, and what each
    // port has been told.
    int              owner = OWN_NONE;
    int              data_wins_over_fetch = 0;
    bit              fetch_discarded = 0;
    bit              m_en = 0, m_we = 0;
    logic [AB-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
    bit              m_if_done = 0, m_d_done = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        bit wants_fetch, wants_data, done_i, done_d;
        int winner;
        done_i = 0;
        done_d = 0;
        if (rst) begin
            owner = OWN_NONE; data_wins_over_fetch = 0; fetch_discarded = 0;
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_if_rdata = '0; m_d_rdata = '0; m_if_done = 0; m_d_done = 0;
            return;
        end
        if (owner == OWN_NONE) begin
            wants_fetch = if_req && !m_if_done && !if_flush;
            wants_data  = d_req && !m_d_done;
            winner = OWN_NONE;
            if (wants_fetch && wants_data)
                winner = (data_wins_over_fetch == SM) ? OWN_FETCH : OWN_DATA;
            else if (wants_fetch) winner = OWN_FETCH;
            else if (wants_data)  winner = OWN_DATA;
            fetch_discarded = 0;
            if (winner == OWN_FETCH) begin
                owner = OWN_FETCH; m_en = 1; m_we = 0; m_addr = if_addr;
                data_wins_over_fetch = 0;
            end else if (winner == OWN_DATA) begin
                owner = OWN_DATA; m_en = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                if (if_req) data_wins_over_fetch = (data_wins_over_fetch + 1 > SM) ? SM : data_wins_over_fetch + 1;
                else        data_wins_over_fetch = 0;
            end else if (!if_req) begin
                data_wins_over_fetch = 0;
            end
        end else if (owner == OWN_FETCH) begin
            if (if_flush) fetch_discarded = 1;
            if (mem_ready) begin
                owner = OWN_NONE; m_en = 0;
                if (!fetch_discarded) begin done_i = 1; m_if_rdata = mem_rdata; end
                fetch_discarded = 0;
            end
        end else begin
            if (mem_ready) begin
                owner = OWN_NONE; m_en = 0; done_d = 1;
                if (!m_we) m_d_rdata = mem_rdata;
            end
        end
        m_if_done = done_i;
        m_d_done  = done_d;
    endtask

    task automatic check_outputs();
        check("mem_en",   64'(mem_en),   64'(m_en));
        check("if_done",  64'(if_done),  64'(m_if_done));
        check("d_done",   64'(d_done),   64'(m_d_done));
        check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
        check("d_rdata",  64'(d_rdata),  64'(m_d_rdata));
        check("done_excl", 64'(if_done & d_done), 64'd0);
        if (m_en) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_we",   64'(mem_we),   64'(m_we));
            if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    endtask

    // One clock: stalls checked with the new inputs, model advanced on the
    // edge, registered outputs compared on the following falling edge.
    task automatic step();
        #1;
        check("if_stall", 64'(if_stall), 64'(if_req & ~m_if_done));
        check("d_stall",  64'(d_stall),  64'(d_req & ~m_d_done));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        rst = 0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 0; mem_rdata = '0;
    endtask

    initial begin
        logic [XLEN-1:0] saved_data;
        logic [AB-1:0]   saved_addr;
        int run, fetches, dones;
        bit prev_en;

        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();
        step();
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);

        // Single fetch, fastest memory.
        idle_inputs();
        if_req = 1; if_addr = 8'h05;
        step();
        check("f_en", 64'(mem_en), 64'd1);
        check("f_addr", 64'(mem_addr), 64'h05);
        check("f_we", 64'(mem_we), 64'd0);
        mem_ready = 1; mem_rdata = 32'h00A00093;
        step();
        check("f_done", 64'(if_done), 64'd1);
        check("f_rdata", 64'(if_rdata), 64'h00A00093);
        if_req = 0; mem_ready = 0;
        step();
        check("f_pulse", 64'(if_done), 64'd0);

        // Store then load of the same word.
        d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
        step();
        check("st_we", 64'(mem_we), 64'd1);
        check("st_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'h12345678;
        step();
        check("st_done", 64'(d_done), 64'd1);
        check("st_rdata_kept", 64'(d_rdata), 64'd0);
        d_we = 0; mem_ready = 0;
        step();
        step();
        check("ld_we", 64'(mem_we), 64'd0);
        check("ld_addr", 64'(mem_addr), 64'h10);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        step();
        check("ld_done", 64'(d_done), 64'd1);
        check("ld_rdata", 64'(d_rdata), 64'hDEADBEEF);
        d_req = 0; mem_ready = 0;
        step();

        // Flushed fetch followed by a normal fetch.
        if_req = 1; if_addr = 8'h20;
        step();
        saved_data = if_rdata;
        if_flush = 1;
        step();
        if_flush = 0; if_addr = 8'h08;
        step();
        step();
        mem_ready = 1; mem_rdata = 32'h11111111;
        step();
        check("fl_no_done", 64'(if_done), 64'd0);
        check("fl_rdata_kept", 64'(if_rdata), 64'(saved_data));
        mem_ready = 0; mem_rdata = 32'h00000513;
        step();
        check("fl_next_addr", 64'(mem_addr), 64'h08);
        mem_ready = 1;
        step();
        check("fl_next_done", 64'(if_done), 64'd1);
        check("fl_next_rdata", 64'(if_rdata), 64'h00000513);
        if_req = 0; mem_ready = 0;
        step();

        // Contention with both requesters always asking.
        if_req = 1; if_addr = 8'h01; d_req = 1; d_we = 0; d_addr = 8'h02; mem_ready = 1;
        run = 0; fetches = 0; prev_en = mem_en;
        repeat (40) begin
            mem_rdata = $urandom;
            step();
            if (mem_en && !prev_en) begin
                if (mem_addr == 8'h01) begin
                    check("starve_bound", 64'(run <= SM), 64'd1);
                    run = 0; fetches++;
                end else run++;
            end
            prev_en = mem_en;
        end
        check("fetch_served", 64'(fetches > 0), 64'd1);
        idle_inputs();
        step();
        step();

        // Slow memory store.
        d_req = 1; d_we = 1; d_addr = 8'h33; d_wdata = 32'hCAFEF00D;
        step();
        saved_addr = mem_addr; saved_data = mem_wdata;
        dones = 0;
        repeat (10) begin
            d_addr = 8'($urandom); d_wdata = $urandom;
            step();
            check("slow_addr", 64'(mem_addr), 64'(saved_addr));
            check("slow_wdata", 64'(mem_wdata), 64'(saved_data));
            check("slow_stall", 64'(d_stall), 64'd1);
            dones += int'(d_done);
        end
        mem_ready = 1;
        step();
        dones += int'(d_done);
        d_req = 0; mem_ready = 0;
        step();
        dones += int'(d_done);
        check("slow_one_done", 64'(dones), 64'd1);

        // Reset in the middle of a data load.
        d_req = 1; d_we = 0; d_addr = 8'h44;
        step();
        step();
        rst = 1; mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
        step();
        check("rm_en", 64'(mem_en), 64'd0);
        check("rm_done", 64'(d_done), 64'd0);
        check("rm_d_rdata", 64'(d_rdata), 64'd0);
        check("rm_if_rdata", 64'(if_rdata), 64'd0);
        check("rm_mem_addr", 64'(mem_addr), 64'd0);
        rst = 0; d_req = 0;
        step();
        check("rm_done_after", 64'(d_done), 64'd0);
        check("rm_en_after", 64'(mem_en), 64'd0);
        mem_ready = 0;

        // Random traffic.
        repeat (800) begin
            rst       = ($urandom_range(0, 63) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            if_flush  = ($urandom_range(0, 9) == 0);
            if_addr   = 8'($urandom);
            d_req     = ($urandom_range(0, 2) != 0);
            d_we      = 1'($urandom_range(0, 1));
            d_addr    = 8'($urandom);
            d_wdata   = $urandom;
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
